// File: rtl/tiger_defines.sv
// tiger_defines -- shared ALU opcode encodings for the tiger datapath.
// The UNSIGNED bit is ORed onto ADD, SUB and SLT to select their unsigned
// flavour. Any other combination is an unlisted opcode and yields zero.
package tiger_defines;

    localparam int ALU_OP_W = 5;

    localparam logic [ALU_OP_W-1:0] ALU_AND      = 5'h00;
    localparam logic [ALU_OP_W-1:0] ALU_OR       = 5'h01;
    localparam logic [ALU_OP_W-1:0] ALU_ADD      = 5'h02;
    localparam logic [ALU_OP_W-1:0] ALU_XOR      = 5'h03;
    localparam logic [ALU_OP_W-1:0] ALU_NOR      = 5'h04;
    localparam logic [ALU_OP_W-1:0] ALU_SUB      = 5'h06;
    localparam logic [ALU_OP_W-1:0] ALU_SLT      = 5'h07;
    localparam logic [ALU_OP_W-1:0] ALU_LUI      = 5'h08;
    localparam logic [ALU_OP_W-1:0] ALU_SLL      = 5'h09;
    localparam logic [ALU_OP_W-1:0] ALU_SRL      = 5'h0A;
    localparam logic [ALU_OP_W-1:0] ALU_SRA      = 5'h0B;
    localparam logic [ALU_OP_W-1:0] ALU_UNSIGNED = 5'h10;

    // Signed add/sub are the only ops that can raise the overflow flag.
    function automatic logic is_signed_arith(input logic [ALU_OP_W-1:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB);
    endfunction

endpackage

// File: rtl/tiger_alu_core.sv
// tiger_alu_core -- combinational ALU result datapath.
// Ports:
//   srca       : operand A; shift amount for shift ops (low $clog2(WIDTH) bits)
//   srcb       : operand B; value shifted for shift ops
//   alucontrol : opcode (tiger_defines ALU_*)
//   result     : ALU result, zero for unlisted opcodes
//   ovf        : signed overflow of ADD/SUB
// Build option: TIGER_ALU_OVF_EN enables the overflow logic; otherwise ovf is
// tied low and no overflow logic exists.
module tiger_alu_core
    import tiger_defines::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]    srca,
    input  logic [WIDTH-1:0]    srcb,
    input  logic [ALU_OP_W-1:0] alucontrol,
    output logic [WIDTH-1:0]    result,
    output logic                ovf
);

    localparam int SH_W = $clog2(WIDTH);

    logic [SH_W-1:0]  shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic             lt_s;
    logic             lt_u;

    assign shamt = srca[SH_W-1:0];
    assign sum   = srca + srcb;
    assign diff  = srca - srcb;
    assign lt_s  = $signed(srca) < $signed(srcb);
    assign lt_u  = srca < srcb;

    always_comb begin
        result = '0;
        case (alucontrol)
            ALU_ADD, ALU_ADD | ALU_UNSIGNED: result = sum;
            ALU_SUB, ALU_SUB | ALU_UNSIGNED: result = diff;
            ALU_AND:                         result = srca & srcb;
            ALU_OR:                          result = srca | srcb;
            ALU_XOR:                         result = srca ^ srcb;
            ALU_NOR:                         result = ~(srca | srcb);
            ALU_SLT:                         result = {{(WIDTH-1){1'b0}}, lt_s};
            ALU_SLT | ALU_UNSIGNED:          result = {{(WIDTH-1){1'b0}}, lt_u};
            ALU_LUI:                         result = {srcb[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
            ALU_SLL:                         result = srcb << shamt;
            ALU_SRL:                         result = srcb >> shamt;
            ALU_SRA:                         result = $unsigned($signed(srcb) >>> shamt);
            default:                         result = '0;
        endcase
    end

`ifdef TIGER_ALU_OVF_EN
    // Overflow when the operands (B negated for SUB) share a sign that the
    // result does not.
    always_comb begin
        ovf = 1'b0;
        if (is_signed_arith(alucontrol)) begin
            if (alucontrol == ALU_ADD)
                ovf = (srca[WIDTH-1] == srcb[WIDTH-1]) && (sum[WIDTH-1] != srca[WIDTH-1]);
            else
                ovf = (srca[WIDTH-1] != srcb[WIDTH-1]) && (diff[WIDTH-1] != srca[WIDTH-1]);
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/tiger_alu_pipe.sv
// tiger_alu_pipe -- 2-stage valid/ready ALU pipeline.
// S1 registers operands/opcode/tag; tiger_alu_core computes between S1 and
// S2; S2 (the output registers) holds result/tag/ovf.
// Ports:
//   clk, reset_n         : clock, async active-low reset
//   in_valid/in_ready    : input handshake
//   srca, srcb           : operands (srca = shift amount for shifts)
//   alucontrol, in_tag   : opcode, sideband tag
//   out_valid/out_ready  : output handshake
//   aluout, out_tag      : result and its tag
//   out_ovf              : signed overflow (only with TIGER_ALU_OVF_EN)
// Build option: TIGER_ALU_OVF_EN (see tiger_alu_core).
module tiger_alu_pipe
    import tiger_defines::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    srca,
    input  logic [WIDTH-1:0]    srcb,
    input  logic [ALU_OP_W-1:0] alucontrol,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    aluout,
    output logic [TAG_W-1:0]    out_tag,
    output logic                out_ovf
);

    typedef struct packed {
        logic [WIDTH-1:0]    a;
        logic [WIDTH-1:0]    b;
        logic [ALU_OP_W-1:0] op;
        logic [TAG_W-1:0]    tag;
    } s1_req_t;

    s1_req_t          s1;
    logic             s1_valid;
    logic             s2_free;
    logic [WIDTH-1:0] core_res;
    logic             core_ovf;

    // S2 can take a new entry when empty or being drained this cycle; S1 can
    // take one when empty or when its content moves into S2.
    assign s2_free  = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_free;

    tiger_alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .srca       (s1.a),
        .srcb       (s1.b),
        .alucontrol (s1.op),
        .result     (core_res),
        .ovf        (core_ovf)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1        <= '0;
            out_valid <= 1'b0;
            aluout    <= '0;
            out_tag   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            // S2: data only loads with a real op, so a stalled or drained
            // output keeps its last value.
            if (s2_free) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    aluout  <= core_res;
                    out_tag <= s1.tag;
                    out_ovf <= core_ovf;
                end
            end
            // S1
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1.a   <= srca;
                    s1.b   <= srcb;
                    s1.op  <= alucontrol;
                    s1.tag <= in_tag;
                end
            end
        end
    end

endmodule

// File: tb/tb_tiger_alu_pipe.sv
module tb_tiger_alu_pipe;
    import tiger_defines::*;

`ifdef TIGER_ALU_OVF_EN
    localparam logic OVF_ON = 1'b1;
`else
    localparam logic OVF_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] srca = '0;
    logic [31:0] srcb = '0;
    logic [4:0]  alucontrol = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] aluout;
    logic [3:0]  out_tag;
    logic        out_ovf;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    tiger_alu_pipe #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .srca(srca), .srcb(srcb), .alucontrol(alucontrol), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .aluout(aluout),
        .out_tag(out_tag), .out_ovf(out_ovf)
    );

    task automatic test_reset();
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        total++; if (aluout !== 32'h0) begin bad++; $display("FAIL reset_aluout got %h want 0", aluout); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL reset_out_tag got %h want 0", out_tag); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got %b want 0", out_ovf); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    endtask

    // Single op, output always ready: offered in cycle 0, out_valid in cycle 2.
    task automatic test_op(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] tag,
                           input logic [31:0] exp, input logic exp_ovf);
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; alucontrol = op; srca = a; srcb = b; in_tag = tag;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL %s in_ready got %b want 1", name, in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL %s early_valid got %b want 0", name, out_valid); end
        @(negedge clk);
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL %s out_valid got %b want 1", name, out_valid); end
        total++; if (aluout !== exp) begin bad++; $display("FAIL %s aluout got %h want %h", name, aluout, exp); end
        total++; if (out_tag !== tag) begin bad++; $display("FAIL %s out_tag got %h want %h", name, out_tag, tag); end
        total++; if (out_ovf !== exp_ovf) begin bad++; $display("FAIL %s out_ovf got %b want %b", name, out_ovf, exp_ovf); end
    endtask

    task automatic test_alu_ops();
        test_op("add_ovf",  ALU_ADD, 32'h7FFFFFFF, 32'h1, 4'd3, 32'h80000000, OVF_ON);
        test_op("addu",     ALU_ADD | ALU_UNSIGNED, 32'h7FFFFFFF, 32'h1, 4'd1, 32'h80000000, 1'b0);
        test_op("sub",      ALU_SUB, 32'd5, 32'd7, 4'd2, 32'hFFFFFFFE, 1'b0);
        test_op("sub_ovf",  ALU_SUB, 32'h80000000, 32'h1, 4'd4, 32'h7FFFFFFF, OVF_ON);
        test_op("and",      ALU_AND, 32'h0000F0F0, 32'h0000FF00, 4'd5, 32'h0000F000, 1'b0);
        test_op("or",       ALU_OR,  32'h0000F0F0, 32'h0000FF00, 4'd6, 32'h0000FFF0, 1'b0);
        test_op("xor",      ALU_XOR, 32'h0000F0F0, 32'h0000FF00, 4'd7, 32'h00000FF0, 1'b0);
        test_op("nor",      ALU_NOR, 32'h0, 32'h0, 4'd8, 32'hFFFFFFFF, 1'b0);
        test_op("slt",      ALU_SLT, 32'hFFFFFFFF, 32'h1, 4'd9, 32'h1, 1'b0);
        test_op("sltu",     ALU_SLT | ALU_UNSIGNED, 32'hFFFFFFFF, 32'h1, 4'd10, 32'h0, 1'b0);
        test_op("sra",      ALU_SRA, 32'h24, 32'h80000000, 4'd11, 32'hF8000000, 1'b0);
        test_op("srl",      ALU_SRL, 32'h24, 32'h80000000, 4'd12, 32'h08000000, 1'b0);
        test_op("sll",      ALU_SLL, 32'h4, 32'h1, 4'd13, 32'h00000010, 1'b0);
        test_op("lui",      ALU_LUI, 32'h0, 32'h1234, 4'd14, 32'h12340000, 1'b0);
        test_op("unlisted", 5'h1F, 32'h7FFFFFFF, 32'h1, 4'd15, 32'h0, 1'b0);
    endtask

    // Four ADDs on consecutive cycles, out_ready high: one result per cycle.
    task automatic test_back_to_back();
        logic [31:0] exp;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            out_ready = 1'b1;
            if (c < 4) begin
                in_valid = 1'b1; alucontrol = ALU_ADD; srca = 32'(c * 16); srcb = 32'h1; in_tag = 4'(c);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 4) begin
                total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b in_ready c=%0d got %b want 1", c, in_ready); end
            end
            if (c >= 2 && c < 6) begin
                exp = 32'((c - 2) * 16 + 1);
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL b2b out_valid c=%0d got %b want 1", c, out_valid); end
                total++; if (aluout !== exp) begin bad++; $display("FAIL b2b aluout c=%0d got %h want %h", c, aluout, exp); end
                total++; if (out_tag !== 4'(c - 2)) begin bad++; $display("FAIL b2b out_tag c=%0d got %h want %h", c, out_tag, 4'(c - 2)); end
            end
            if (c == 6) begin
                total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b drained got %b want 0", out_valid); end
            end
        end
    endtask

    // out_ready low for 5 cycles while 4 ops are offered; op i = 0x100 + 3*i.
    task automatic test_backpressure();
        int idx = 0;
        int nxt = 0;
        logic exp_rdy;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            if (idx < 4) begin
                in_valid = 1'b1; alucontrol = ALU_ADD; srca = 32'(idx * 3); srcb = 32'h100; in_tag = 4'(8 + idx);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (c < 5) begin
                exp_rdy = (c < 2);
                total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL bp in_ready c=%0d got %b want %b", c, in_ready, exp_rdy); end
            end
            if (c >= 2 && c < 5) begin
                total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp hold_valid c=%0d got %b want 1", c, out_valid); end
                total++; if (aluout !== 32'h100) begin bad++; $display("FAIL bp hold_aluout c=%0d got %h want 00000100", c, aluout); end
                total++; if (out_tag !== 4'd8) begin bad++; $display("FAIL bp hold_tag c=%0d got %h want 8", c, out_tag); end
            end
            if (out_valid && out_ready) begin
                total++;
                if (nxt >= 4) begin
                    bad++; $display("FAIL bp extra_result got %h want none", aluout);
                end else if (aluout !== 32'(32'h100 + nxt * 3) || out_tag !== 4'(8 + nxt)) begin
                    bad++; $display("FAIL bp order got %h/%h want %h/%h", aluout, out_tag, 32'(32'h100 + nxt * 3), 4'(8 + nxt));
                end
                nxt++;
            end
            if (in_valid && in_ready) idx++;
        end
        in_valid = 1'b0;
        total++; if (idx !== 4) begin bad++; $display("FAIL bp accepted got %0d want 4", idx); end
        total++; if (nxt !== 4) begin bad++; $display("FAIL bp delivered got %0d want 4", nxt); end
    endtask

    // Two ops in flight (S2 stalled, S1 full), then an async reset pulse.
    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; alucontrol = ALU_OR; srca = 32'h11; srcb = 32'h22; in_tag = 4'd5;
        @(negedge clk);
        srca = 32'h33; in_tag = 4'd6;
        @(negedge clk);
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b1 || aluout !== 32'h33) begin bad++; $display("FAIL rmid inflight got %b/%h want 1/00000033", out_valid, aluout); end
        #2 reset_n = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid out_valid got %b want 0", out_valid); end
        total++; if (aluout !== 32'h0) begin bad++; $display("FAIL rmid aluout got %h want 0", aluout); end
        total++; if (out_tag !== 4'h0) begin bad++; $display("FAIL rmid out_tag got %h want 0", out_tag); end
        total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL rmid out_ovf got %b want 0", out_ovf); end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1; out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rmid in_ready got %b want 1", in_ready); end
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rmid stale c=%0d got %b want 0", c, out_valid); end
        end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_op("post_reset", ALU_ADD, 32'h10, 32'h20, 4'd7, 32'h30, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
